vtc_prog: RTL and testbench
===========================

Name: vtc_prog

Overview:
Runtime-programmable video timing controller, the successor to the fixed-mode timing generator. It produces registered hsync, vsync, data-enable, early data-enable and active-pixel coordinates for any raster that fits in X_BITS/Y_BITS. Timing fields are staged from a config interface and applied only at frame boundaries, so mode changes are glitch-free. It sits between the pixel-clock domain config logic and the HDMI/LCD output path and pattern/frame-buffer readers.

Parameters:
X_BITS, 12, width of horizontal counters and timing fields
Y_BITS, 12, width of vertical counters and timing fields
H_TOTAL_D/H_SYNC_D/H_BP_D/H_ACT_D, 2200/44/148/1920, reset horizontal timing (1080p60)
V_TOTAL_D/V_SYNC_D/V_BP_D/V_ACT_D, 1125/5/36/1080, reset vertical timing

Ports:
clk  in  1  pixel clock
rstn  in  1  synchronous active-low reset
run  in  1  1 = generate timing; 0 = hold counters at 0
cfg_update  in  1  one-cycle pulse: stage all cfg_* fields
cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act  in  X_BITS each  horizontal timing
cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act  in  Y_BITS each  vertical timing
cfg_hs_pol, cfg_vs_pol  in  1 each  1 = active-high sync
cfg_err  out  1  sticky: last staged config invalid
cfg_pending  out  1  staged config waiting for frame end
hs_out, vs_out, de_out  out  1 each  sync/enable, polarity applied to syncs
de_pre  out  1  de_out one cycle early
x_act  out  X_BITS  active column, 0 outside active
y_act  out  Y_BITS  active row, 0 outside active
frame_start  out  1  one-cycle pulse, h=0 v=0
line_start  out  1  one-cycle pulse, each h=0
frame_cnt  out  16  frames completed, wraps

Behaviour:
- Reset (rstn=0 at clk edge): counters 0; active and staged regs = *_D defaults, pol = 1; cfg_err=0, cfg_pending=0; de_out, de_pre, frame_start, line_start, frame_cnt, x_act, y_act = 0; hs_out = ~hs_pol, vs_out = ~vs_pol (inactive). Reset mid-frame restarts at h=0, v=0 on defaults.
- Counters: h counts 0..h_total-1 then wraps; v increments when h==h_total-1, wraps at v_total-1. run=0: h,v forced 0, all outputs at reset/inactive levels, frame_cnt held.
- All outputs registered: value at cycle n+1 is function of counters at cycle n (1-cycle latency).
- hs active when h < h_sync. vs active when v < v_sync (transitions aligned to h==0). Output = active XNOR pol.
- de active when v in [v_sync+v_bp, v_sync+v_bp+v_act-1] and h in [h_sync+h_bp, h_sync+h_bp+h_act-1]. de_pre uses horizontal window shifted one count earlier, same vertical window.
- x_act = h-(h_sync+h_bp) and y_act = v-(v_sync+v_bp) when inside respective windows, else 0; width truncation to X_BITS/Y_BITS.
- line_start when h==0; frame_start when h==0 and v==0; frame_cnt += 1 at each frame_start after the first since run rose.
- Config: on cfg_update, check h_sync+h_bp+h_act < h_total, v_sync+v_bp+v_act < v_total, all fields non-zero (sums computed at X_BITS+1/Y_BITS+1). Valid: copy to staged, cfg_pending=1, cfg_err=0. Invalid: staged unchanged, cfg_err=1.
- Apply: when cfg_pending and h==h_total-1 and v==v_total-1 (or run=0), active<=staged, cfg_pending=0. cfg_update in the same cycle as apply: new values staged, pending stays 1, applied at next frame end.
- Back-to-back cfg_update: last valid one wins.

Optional Feature:
VTC_PATTERN_EN: when defined, adds output pat_rgb (24 bits) = 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), bar = x_act*8/h_act, aligned with de_out, 0 when de_out=0. When undefined, port and logic absent; all other behaviour identical.

Test Plan:
- Reset then run=1 on defaults -> hs_out high 44 cycles per 2200-cycle line; first de_out at v=41, h=192 (x_act=0); 1920 de cycles per line; frame_start every 2475000 cycles.
- Program 1280x720 (1650/40/220/1280, 750/5/20/720) mid-frame -> cfg_pending=1; old timing completes frame; next frame_start uses 1650-cycle lines, cfg_pending=0.
- cfg_update with h_sync+h_bp+h_act=h_total -> cfg_err=1, timing unchanged, cfg_pending unchanged.
- cfg_hs_pol=0, cfg_vs_pol=0 applied -> hs_out low 44 cycles per line, vs_out low 5 lines; idle levels high.
- de_pre checked against de_out -> de_pre rises/falls exactly one cycle before de_out on every active line.
- Assert rstn=0 mid-line after new mode applied -> next cycle outputs at reset values; timing resumes on 1080p defaults at h=0,v=0.

Source files
------------

// File: rtl/vtc_prog_if.sv
// vtc_prog_if: configuration bus of the programmable video timing controller.
//   master : drives cfg_update pulse, horizontal/vertical timing fields and
//            sync polarities; observes cfg_err / cfg_pending.
//   slave  : the timing controller (vtc_prog).
// Parameters X_BITS / Y_BITS set the horizontal / vertical field widths.
interface vtc_prog_if #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
);
    logic              cfg_update;
    logic [X_BITS-1:0] cfg_h_total;
    logic [X_BITS-1:0] cfg_h_sync;
    logic [X_BITS-1:0] cfg_h_bp;
    logic [X_BITS-1:0] cfg_h_act;
    logic [Y_BITS-1:0] cfg_v_total;
    logic [Y_BITS-1:0] cfg_v_sync;
    logic [Y_BITS-1:0] cfg_v_bp;
    logic [Y_BITS-1:0] cfg_v_act;
    logic              cfg_hs_pol;
    logic              cfg_vs_pol;
    logic              cfg_err;
    logic              cfg_pending;

    modport master (
        output cfg_update, cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act,
               cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act, cfg_hs_pol, cfg_vs_pol,
        input  cfg_err, cfg_pending
    );

    modport slave (
        input  cfg_update, cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act,
               cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act, cfg_hs_pol, cfg_vs_pol,
        output cfg_err, cfg_pending
    );
endinterface

// File: rtl/vtc_prog.sv
// vtc_prog: runtime-programmable video timing controller.
// Generates registered hsync/vsync/data-enable/early data-enable, active pixel
// coordinates and line/frame strobes for any raster fitting X_BITS/Y_BITS.
// Timing fields arrive over the cfg interface, are validated and staged, and
// become active only at a frame boundary (or immediately while run=0).
// Ports:
//   clk, rstn (synchronous, active-low), run (0 = counters held at 0, idle outputs)
//   cfg          : vtc_prog_if.slave configuration bus (update pulse, fields, err/pending)
//   hs_out, vs_out, de_out, de_pre : sync/enable outputs (sync polarity applied)
//   x_act, y_act : active column/row, 0 outside their own window
//   line_start, frame_start : one-cycle strobes at h=0 / h=0,v=0
//   frame_cnt    : completed-frame counter
// Optional feature macro: VTC_PATTERN_EN adds pat_rgb, an 8-bar colour pattern
// aligned with de_out.
module vtc_prog #(
    parameter int X_BITS    = 12,
    parameter int Y_BITS    = 12,
    parameter int H_TOTAL_D = 2200,
    parameter int H_SYNC_D  = 44,
    parameter int H_BP_D    = 148,
    parameter int H_ACT_D   = 1920,
    parameter int V_TOTAL_D = 1125,
    parameter int V_SYNC_D  = 5,
    parameter int V_BP_D    = 36,
    parameter int V_ACT_D   = 1080
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    vtc_prog_if.slave         cfg,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic              de_pre,
    output logic [X_BITS-1:0] x_act,
    output logic [Y_BITS-1:0] y_act,
    output logic              frame_start,
    output logic              line_start,
    output logic [15:0]       frame_cnt
`ifdef VTC_PATTERN_EN
    ,
    output logic [23:0]       pat_rgb
`endif
);

    typedef struct packed {
        logic [X_BITS-1:0] h_total;
        logic [X_BITS-1:0] h_sync;
        logic [X_BITS-1:0] h_bp;
        logic [X_BITS-1:0] h_act;
        logic [Y_BITS-1:0] v_total;
        logic [Y_BITS-1:0] v_sync;
        logic [Y_BITS-1:0] v_bp;
        logic [Y_BITS-1:0] v_act;
        logic              hs_pol;
        logic              vs_pol;
    } timing_t;

    localparam timing_t TIM_DEF = '{
        h_total: X_BITS'(H_TOTAL_D), h_sync: X_BITS'(H_SYNC_D),
        h_bp:    X_BITS'(H_BP_D),    h_act:  X_BITS'(H_ACT_D),
        v_total: Y_BITS'(V_TOTAL_D), v_sync: Y_BITS'(V_SYNC_D),
        v_bp:    Y_BITS'(V_BP_D),    v_act:  Y_BITS'(V_ACT_D),
        hs_pol:  1'b1,               vs_pol: 1'b1
    };

    localparam logic [X_BITS-1:0] X_ZERO  = X_BITS'(0);
    localparam logic [X_BITS-1:0] X_ONE   = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ZERO  = Y_BITS'(0);
    localparam logic [Y_BITS-1:0] Y_ONE   = Y_BITS'(1);
    localparam logic [X_BITS:0]   XW_ONE  = (X_BITS+1)'(1);

    timing_t           act_q, act_d, stg_q, stg_d, new_s;
    logic [X_BITS-1:0] h_q, h_d, x_q, x_d, x_rel_s;
    logic [Y_BITS-1:0] v_q, v_d, y_q, y_d, y_rel_s;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d, pend_q, pend_d, started_q, started_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, de_pre_q, de_pre_d;
    logic              fs_q, fs_d, ls_q, ls_d;
    logic [X_BITS:0]   new_h_sum_s, h_start_s, h_end_s, h_ext_s, h_nxt_s;
    logic [Y_BITS:0]   new_v_sum_s, v_start_s, v_end_s, v_ext_s;
    logic              cfg_ok_s, h_last_s, v_last_s, apply_s;
    logic              h_win_s, h_pre_s, v_win_s;

    // Candidate configuration and its validity (sums one bit wider than the fields).
    assign new_s = '{
        h_total: cfg.cfg_h_total, h_sync: cfg.cfg_h_sync, h_bp: cfg.cfg_h_bp, h_act: cfg.cfg_h_act,
        v_total: cfg.cfg_v_total, v_sync: cfg.cfg_v_sync, v_bp: cfg.cfg_v_bp, v_act: cfg.cfg_v_act,
        hs_pol:  cfg.cfg_hs_pol,  vs_pol: cfg.cfg_vs_pol
    };
    assign new_h_sum_s = {1'b0, cfg.cfg_h_sync} + {1'b0, cfg.cfg_h_bp} + {1'b0, cfg.cfg_h_act};
    assign new_v_sum_s = {1'b0, cfg.cfg_v_sync} + {1'b0, cfg.cfg_v_bp} + {1'b0, cfg.cfg_v_act};
    assign cfg_ok_s = (new_h_sum_s < {1'b0, cfg.cfg_h_total}) && (new_v_sum_s < {1'b0, cfg.cfg_v_total}) &&
                      (cfg.cfg_h_total != X_ZERO) && (cfg.cfg_h_sync != X_ZERO) &&
                      (cfg.cfg_h_bp != X_ZERO)    && (cfg.cfg_h_act != X_ZERO) &&
                      (cfg.cfg_v_total != Y_ZERO) && (cfg.cfg_v_sync != Y_ZERO) &&
                      (cfg.cfg_v_bp != Y_ZERO)    && (cfg.cfg_v_act != Y_ZERO);

    // Frame boundary: staged timing may only replace active timing here or while idle.
    assign h_last_s = (h_q == (act_q.h_total - X_ONE));
    assign v_last_s = (v_q == (act_q.v_total - Y_ONE));
    assign apply_s  = pend_q && (!run || (h_last_s && v_last_s));

    // Active windows; de_pre looks at the next horizontal count.
    assign h_start_s = {1'b0, act_q.h_sync} + {1'b0, act_q.h_bp};
    assign h_end_s   = h_start_s + {1'b0, act_q.h_act};
    assign h_ext_s   = {1'b0, h_q};
    assign h_nxt_s   = h_ext_s + XW_ONE;
    assign h_win_s   = (h_ext_s >= h_start_s) && (h_ext_s < h_end_s);
    assign h_pre_s   = (h_nxt_s >= h_start_s) && (h_nxt_s < h_end_s);
    assign v_start_s = {1'b0, act_q.v_sync} + {1'b0, act_q.v_bp};
    assign v_end_s   = v_start_s + {1'b0, act_q.v_act};
    assign v_ext_s   = {1'b0, v_q};
    assign v_win_s   = (v_ext_s >= v_start_s) && (v_ext_s < v_end_s);
    assign x_rel_s   = h_q - h_start_s[X_BITS-1:0];
    assign y_rel_s   = v_q - v_start_s[Y_BITS-1:0];

    // Configuration staging, validation and frame-boundary apply.
    always_comb begin
        act_d  = act_q;
        stg_d  = stg_q;
        pend_d = pend_q;
        err_d  = err_q;
        if (apply_s) begin
            act_d  = stg_q;
            pend_d = 1'b0;
        end else begin
            act_d  = act_q;
        end
        // An update landing on the apply cycle re-arms pending for the next frame end.
        if (cfg.cfg_update) begin
            if (cfg_ok_s) begin
                stg_d  = new_s;
                pend_d = 1'b1;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end else begin
            stg_d = stg_q;
        end
    end

    // Horizontal/vertical raster counters.
    always_comb begin
        h_d = X_ZERO;
        v_d = Y_ZERO;
        if (run) begin
            h_d = h_last_s ? X_ZERO : (h_q + X_ONE);
            if (h_last_s) begin
                v_d = v_last_s ? Y_ZERO : (v_q + Y_ONE);
            end else begin
                v_d = v_q;
            end
        end else begin
            h_d = X_ZERO;
            v_d = Y_ZERO;
        end
    end

    // Output decode from the current counters; idle levels use the polarity about to be active.
    always_comb begin
        hs_d        = ~act_d.hs_pol;
        vs_d        = ~act_d.vs_pol;
        de_d        = 1'b0;
        de_pre_d    = 1'b0;
        x_d         = X_ZERO;
        y_d         = Y_ZERO;
        ls_d        = 1'b0;
        fs_d        = 1'b0;
        started_d   = started_q;
        frame_cnt_d = frame_cnt_q;
        if (run) begin
            hs_d     = (h_q < act_q.h_sync) ~^ act_q.hs_pol;
            vs_d     = (v_q < act_q.v_sync) ~^ act_q.vs_pol;
            de_d     = h_win_s && v_win_s;
            de_pre_d = h_pre_s && v_win_s;
            x_d      = h_win_s ? x_rel_s : X_ZERO;
            y_d      = v_win_s ? y_rel_s : Y_ZERO;
            ls_d     = (h_q == X_ZERO);
            fs_d     = (h_q == X_ZERO) && (v_q == Y_ZERO);
            // The first frame_start after run rises opens a frame; later ones close one.
            if (fs_d) begin
                started_d   = 1'b1;
                frame_cnt_d = started_q ? (frame_cnt_q + 16'd1) : frame_cnt_q;
            end else begin
                started_d   = started_q;
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            started_d   = 1'b0;
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_q         <= X_ZERO;
            v_q         <= Y_ZERO;
            act_q       <= TIM_DEF;
            stg_q       <= TIM_DEF;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            started_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            hs_q        <= ~TIM_DEF.hs_pol;
            vs_q        <= ~TIM_DEF.vs_pol;
            de_q        <= 1'b0;
            de_pre_q    <= 1'b0;
            x_q         <= X_ZERO;
            y_q         <= Y_ZERO;
            fs_q        <= 1'b0;
            ls_q        <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            act_q       <= act_d;
            stg_q       <= stg_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            started_q   <= started_d;
            frame_cnt_q <= frame_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            de_pre_q    <= de_pre_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fs_q        <= fs_d;
            ls_q        <= ls_d;
        end
    end

    assign cfg.cfg_err     = err_q;
    assign cfg.cfg_pending = pend_q;
    assign hs_out          = hs_q;
    assign vs_out          = vs_q;
    assign de_out          = de_q;
    assign de_pre          = de_pre_q;
    assign x_act           = x_q;
    assign y_act           = y_q;
    assign frame_start     = fs_q;
    assign line_start      = ls_q;
    assign frame_cnt       = frame_cnt_q;

`ifdef VTC_PATTERN_EN
    // Colour of each of the eight vertical bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        logic [23:0] rgb;
        case (bar)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    logic [X_BITS+2:0] pat_num_s;
    logic [2:0]        bar_s;
    logic [23:0]       pat_q, pat_d;

    // Bar index = x*8/h_act; x < h_act inside the window so the quotient fits 3 bits.
    assign pat_num_s = {x_rel_s, 3'b000};
    assign bar_s     = 3'(pat_num_s / {3'b000, act_q.h_act});

    // Pattern colour, blanked wherever de_out will be low.
    always_comb begin
        pat_d = 24'h000000;
        if (run && h_win_s && v_win_s) begin
            pat_d = bar_colour(bar_s);
        end else begin
            pat_d = 24'h000000;
        end
    end

    // Pattern register, aligned with de_out.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pat_q <= 24'h000000;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat_rgb = pat_q;
`endif

endmodule

// File: tb/tb_vtc_prog.sv
module tb_vtc_prog;
    localparam int XB = 12;
    localparam int YB = 12;

    typedef struct packed {
        int ht; int hs; int hb; int ha;
        int vt; int vs; int vb; int va;
        bit hp; bit vp;
    } tim_t;

    localparam tim_t DEF  = '{2200, 44, 148, 1920, 1125, 5, 36, 1080, 1'b1, 1'b1};
    localparam tim_t M_A  = '{20, 2, 3, 10, 12, 1, 2, 6, 1'b1, 1'b1};
    localparam tim_t M_B  = '{16, 3, 2, 8, 10, 2, 1, 5, 1'b0, 1'b0};
    localparam tim_t M_C  = '{24, 2, 3, 10, 12, 1, 2, 6, 1'b1, 1'b1};
    localparam tim_t BADH = '{2200, 44, 148, 2008, 1125, 5, 36, 1080, 1'b1, 1'b1};
    localparam tim_t BADV = '{16, 3, 2, 8, 10, 2, 3, 5, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rstn, run;
    logic hs_out, vs_out, de_out, de_pre, frame_start, line_start;
    logic [XB-1:0] x_act;
    logic [YB-1:0] y_act;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    vtc_prog_if #(.X_BITS(XB), .Y_BITS(YB)) cfg_if ();

    vtc_prog #(.X_BITS(XB), .Y_BITS(YB)) dut (
        .clk(clk), .rstn(rstn), .run(run), .cfg(cfg_if.slave),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .de_pre(de_pre),
        .x_act(x_act), .y_act(y_act), .frame_start(frame_start),
        .line_start(line_start), .frame_cnt(frame_cnt)
    );

    // Reference model state
    tim_t m_act, m_stg, drv;
    int   mh, mv;
    bit   m_err, m_pend, m_started;
    logic [15:0] m_fcnt;
    logic [47:0] sb_q[$];

    int n_vec = 0, n_miss = 0;
    int n_hs_hi, n_hs_lo, n_vs_lo, n_de, n_ls, n_fs, pre_err, pre_rise;
    bit track_pre = 1'b0;
    logic prev_pre = 1'b0;

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] dut_vec();
        return {cfg_if.cfg_err, cfg_if.cfg_pending, hs_out, vs_out, de_out, de_pre,
                frame_start, line_start, frame_cnt, x_act, y_act};
    endfunction

    task automatic drive(input tim_t t);
        drv = t;
        cfg_if.cfg_h_total = 12'(t.ht); cfg_if.cfg_h_sync = 12'(t.hs);
        cfg_if.cfg_h_bp    = 12'(t.hb); cfg_if.cfg_h_act  = 12'(t.ha);
        cfg_if.cfg_v_total = 12'(t.vt); cfg_if.cfg_v_sync = 12'(t.vs);
        cfg_if.cfg_v_bp    = 12'(t.vb); cfg_if.cfg_v_act  = 12'(t.va);
        cfg_if.cfg_hs_pol  = t.hp;      cfg_if.cfg_vs_pol = t.vp;
    endtask

    // Predict the outputs that appear after the coming clock edge.
    task automatic model_step();
        bit hs_o, vs_o, de_o, dep_o, fs_o, ls_o, hw, hp, vw, app;
        int x, y, hst, vst;
        tim_t nact;
        if (!rstn) begin
            mh = 0; mv = 0; m_act = DEF; m_stg = DEF;
            m_err = 0; m_pend = 0; m_started = 0; m_fcnt = 16'd0;
            sb_q.push_back(48'd0);
        end else begin
            app  = m_pend && (!run || (mh == m_act.ht - 1 && mv == m_act.vt - 1));
            nact = app ? m_stg : m_act;
            if (app) m_pend = 0;
            if (cfg_if.cfg_update) begin
                if (drv.ht > 0 && drv.hs > 0 && drv.hb > 0 && drv.ha > 0 &&
                    drv.vt > 0 && drv.vs > 0 && drv.vb > 0 && drv.va > 0 &&
                    drv.hs + drv.hb + drv.ha < drv.ht && drv.vs + drv.vb + drv.va < drv.vt) begin
                    m_stg = drv; m_pend = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            hs_o = !nact.hp; vs_o = !nact.vp; de_o = 0; dep_o = 0; fs_o = 0; ls_o = 0; x = 0; y = 0;
            if (run) begin
                hst  = m_act.hs + m_act.hb;
                vst  = m_act.vs + m_act.vb;
                hs_o = ((mh < m_act.hs) == m_act.hp);
                vs_o = ((mv < m_act.vs) == m_act.vp);
                hw   = (mh >= hst) && (mh < hst + m_act.ha);
                hp   = (mh + 1 >= hst) && (mh + 1 < hst + m_act.ha);
                vw   = (mv >= vst) && (mv < vst + m_act.va);
                de_o = hw && vw; dep_o = hp && vw;
                x    = hw ? mh - hst : 0;
                y    = vw ? mv - vst : 0;
                ls_o = (mh == 0); fs_o = (mh == 0) && (mv == 0);
                if (fs_o) begin
                    if (m_started) m_fcnt = m_fcnt + 16'd1;
                    m_started = 1;
                end
                if (mh == m_act.ht - 1) begin
                    mh = 0;
                    mv = (mv == m_act.vt - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end else begin
                m_started = 0; mh = 0; mv = 0;
            end
            m_act = nact;
            sb_q.push_back({m_err, m_pend, hs_o, vs_o, de_o, dep_o, fs_o, ls_o, m_fcnt, 12'(x), 12'(y)});
        end
    endtask

    task automatic clr_stats();
        n_hs_hi = 0; n_hs_lo = 0; n_vs_lo = 0; n_de = 0; n_ls = 0; n_fs = 0;
        pre_err = 0; pre_rise = 0;
    endtask

    // One clock: predict, let the edge happen, compare away from the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) check_val("outs", dut_vec(), sb_q.pop_front());
        if (hs_out) n_hs_hi++; else n_hs_lo++;
        if (!vs_out) n_vs_lo++;
        if (de_out) n_de++;
        if (line_start) n_ls++;
        if (frame_start) n_fs++;
        if (track_pre) begin
            if (de_out !== prev_pre) pre_err++;
            if (de_pre && !prev_pre) pre_rise++;
        end
        prev_pre = de_pre;
        @(negedge clk);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_cfg(input tim_t t);
        drive(t);
        cfg_if.cfg_update = 1'b1;
        cycle();
        cfg_if.cfg_update = 1'b0;
    endtask

    task automatic wait_fs(input string tag, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (frame_start) found = 1;
        end
        check_val(tag, 48'(found), 48'd1);
    endtask

    initial begin
        rstn = 1'b0; run = 1'b0; cfg_if.cfg_update = 1'b0;
        drive(DEF);
        clr_stats();
        run_n(2);
        check_val("rst_hs", 48'(hs_out), 48'd0);

        // 1080p defaults: first line
        rstn = 1'b1; run = 1'b1;
        clr_stats(); track_pre = 1'b1;
        run_n(2200);
        check_val("def_hs_hi", 48'(n_hs_hi), 48'd44);
        check_val("def_ls", 48'(n_ls), 48'd1);
        check_val("def_fs", 48'(n_fs), 48'd1);
        check_val("def_de", 48'(n_de), 48'd0);

        // Invalid horizontal sum equal to total
        pulse_cfg(BADH);
        check_val("badh_err", 48'(cfg_if.cfg_err), 48'd1);
        check_val("badh_pend", 48'(cfg_if.cfg_pending), 48'd0);
        run_n(100);

        // Small mode programmed while idle takes effect at once
        run = 1'b0; track_pre = 1'b0;
        pulse_cfg(M_A);
        check_val("a_err_clr", 48'(cfg_if.cfg_err), 48'd0);
        run_n(2);
        check_val("a_pend_idle", 48'(cfg_if.cfg_pending), 48'd0);
        run = 1'b1;
        clr_stats(); track_pre = 1'b1;
        run_n(720);
        check_val("a_fs", 48'(n_fs), 48'd3);
        check_val("a_hs_hi", 48'(n_hs_hi), 48'd72);
        check_val("a_de", 48'(n_de), 48'd180);
        check_val("a_fcnt", 48'(frame_cnt), 48'd2);
        check_val("a_pre_lead", 48'(pre_err), 48'd0);
        check_val("a_pre_rise", 48'(pre_rise), 48'd18);

        // Mid-frame change to active-low mode B
        run_n(50);
        pulse_cfg(M_B);
        check_val("b_pend", 48'(cfg_if.cfg_pending), 48'd1);
        wait_fs("b_fs_wait", 300);
        check_val("b_pend_clr", 48'(cfg_if.cfg_pending), 48'd0);
        clr_stats();
        run_n(160);
        check_val("b_ls", 48'(n_ls), 48'd10);
        check_val("b_fs", 48'(n_fs), 48'd1);
        check_val("b_hs_lo", 48'(n_hs_lo), 48'd30);
        check_val("b_vs_lo", 48'(n_vs_lo), 48'd32);
        check_val("b_de", 48'(n_de), 48'd40);
        check_val("b_pre_lead", 48'(pre_err), 48'd0);

        // Back-to-back updates: last valid one (C) wins, invalid one only flags
        pulse_cfg(M_A);
        pulse_cfg(M_C);
        pulse_cfg(BADV);
        check_val("btb_err", 48'(cfg_if.cfg_err), 48'd1);
        check_val("btb_pend", 48'(cfg_if.cfg_pending), 48'd1);
        wait_fs("c_fs_wait", 300);
        clr_stats();
        run_n(288);
        check_val("c_ls", 48'(n_ls), 48'd12);
        check_val("c_hs_hi", 48'(n_hs_hi), 48'd24);
        check_val("c_fs", 48'(n_fs), 48'd1);

        // Reset mid-line returns to 1080p defaults
        run_n(7);
        rstn = 1'b0; track_pre = 1'b0;
        cycle();
        check_val("rst2_de", 48'(de_out), 48'd0);
        check_val("rst2_fcnt", 48'(frame_cnt), 48'd0);
        rstn = 1'b1;
        clr_stats(); track_pre = 1'b1;
        run_n(2200);
        check_val("rst2_hs_hi", 48'(n_hs_hi), 48'd44);
        check_val("rst2_ls", 48'(n_ls), 48'd1);
        check_val("rst2_fs", 48'(n_fs), 48'd1);
        check_val("rst2_pre_lead", 48'(pre_err), 48'd0);

        check_val("sb_empty", 48'(sb_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
